// File: rtl/mac_seq.sv
// -----------------------------------------------------------------------------
// mac_seq: layer sequencer feeding a single mac unit.
//
// For each of N_OUT neurons it clears the mac, streams N_IN input/weight byte
// pairs from sync-read memories into it, adds the neuron bias to the 16-bit
// accumulator, requantizes (right shift by SHIFT, saturate to 8 bits) and
// offers the byte on a valid/ready output port. One start pulse runs a layer.
//
// Ports
//   CLKEXT                  clock, rising edge
//   RST                     asynchronous active-high reset
//   start                   layer start request, sampled in IDLE only
//   busy / done             not-IDLE flag / 1-cycle end-of-layer pulse
//   x_addr / x_data         input memory address / read data (1-cycle latency)
//   w_addr / w_data         weight memory address (neuron*N_IN + i) / data
//   bias_addr / bias_data   bias memory address (neuron) / unsigned data
//   mac_rst, mac_en         mac accumulator clear / accumulate strobe
//   mac_a, mac_b, mac_bias  mac operands (zero unless mac_en); bias tied 0
//   mac_result              mac registered accumulator
//   y_data, y_idx           requantized result and its neuron index
//   y_valid / y_ready       output handshake
//   dbg_state_o             current FSM state, for observation only
//
// Output handshake: y_valid rises in OUT with y_data/y_idx already stable and
// stays high, with data held, until a cycle where y_valid && y_ready is seen
// at the rising edge; that cycle is the transfer. y_valid never drops without
// a transfer except on RST.
// -----------------------------------------------------------------------------
module mac_seq #(
    parameter int N_IN  = 784,
    parameter int N_OUT = 10,
    parameter int SHIFT = 8,
    parameter int XW    = 10,
    parameter int WW    = 13,
    parameter int NW    = 4
) (
    input  logic          CLKEXT,
    input  logic          RST,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [XW-1:0] x_addr,
    input  logic [7:0]    x_data,
    output logic [WW-1:0] w_addr,
    input  logic [7:0]    w_data,
    output logic [NW-1:0] bias_addr,
    input  logic [7:0]    bias_data,
    output logic          mac_rst,
    output logic          mac_en,
    output logic [7:0]    mac_a,
    output logic [7:0]    mac_b,
    output logic [7:0]    mac_bias,
    input  logic [15:0]   mac_result,
    output logic [7:0]    y_data,
    output logic [NW-1:0] y_idx,
    output logic          y_valid,
    input  logic          y_ready,
    output logic [2:0]    dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_RUN  = 3'd2,
        S_ACC  = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    localparam logic [XW-1:0] K_LAST = XW'(N_IN - 1);
    localparam logic [XW-1:0] K_PEN  = XW'(N_IN - 2);
    localparam logic [NW-1:0] N_LAST = NW'(N_OUT - 1);

    state_t        state_q, state_d;
    logic [NW-1:0] neuron_q, neuron_d;
    logic [XW-1:0] k_q, k_d;
    logic [XW-1:0] x_addr_q, x_addr_d;
    logic [WW-1:0] w_addr_q, w_addr_d;
    logic [NW-1:0] bias_addr_q, bias_addr_d;
    logic [7:0]    y_data_q, y_data_d;
    logic [NW-1:0] y_idx_q, y_idx_d;
    logic          done_q, done_d;
    logic [16:0]   sum17;
    logic [16:0]   q17;

    always_ff @(posedge CLKEXT or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            neuron_q    <= '0;
            k_q         <= '0;
            x_addr_q    <= '0;
            w_addr_q    <= '0;
            bias_addr_q <= '0;
            y_data_q    <= '0;
            y_idx_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            neuron_q    <= neuron_d;
            k_q         <= k_d;
            x_addr_q    <= x_addr_d;
            w_addr_q    <= w_addr_d;
            bias_addr_q <= bias_addr_d;
            y_data_q    <= y_data_d;
            y_idx_q     <= y_idx_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        neuron_d    = neuron_q;
        k_d         = k_q;
        x_addr_d    = x_addr_q;
        w_addr_d    = w_addr_q;
        bias_addr_d = bias_addr_q;
        y_data_d    = y_data_q;
        y_idx_d     = y_idx_q;
        done_d      = 1'b0;
        sum17       = {1'b0, mac_result} + {9'd0, bias_data};
        q17         = sum17 >> SHIFT;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_CLR;
                    neuron_d    = '0;
                    x_addr_d    = '0;
                    w_addr_d    = '0;
                    bias_addr_d = '0;
                end
            end
            S_CLR: begin
                // Addresses for element 0 are on the bus now; element 1 is
                // issued during the first RUN cycle.
                state_d  = S_RUN;
                k_d      = '0;
                x_addr_d = x_addr_q + 1'b1;
                w_addr_d = w_addr_q + 1'b1;
            end
            S_RUN: begin
                k_d = k_q + 1'b1;
                // Stop advancing once the last element's address is issued,
                // so the bus holds that address through the final cycle.
                if (k_q < K_PEN) begin
                    x_addr_d = x_addr_q + 1'b1;
                    w_addr_d = w_addr_q + 1'b1;
                end
                if (k_q == K_LAST) begin
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                y_data_d = (|q17[16:8]) ? 8'hFF : q17[7:0];
                y_idx_d  = neuron_q;
                state_d  = S_OUT;
            end
            S_OUT: begin
                if (y_ready) begin
                    if (neuron_q == N_LAST) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        // w_addr sits on the previous neuron's last weight,
                        // so one more step lands on (neuron+1)*N_IN.
                        state_d     = S_CLR;
                        neuron_d    = neuron_q + 1'b1;
                        x_addr_d    = '0;
                        w_addr_d    = w_addr_q + 1'b1;
                        bias_addr_d = bias_addr_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign x_addr      = x_addr_q;
    assign w_addr      = w_addr_q;
    assign bias_addr   = bias_addr_q;
    assign mac_rst     = (state_q == S_CLR);
    assign mac_en      = (state_q == S_RUN);
    assign mac_a       = mac_en ? x_data : 8'd0;
    assign mac_b       = mac_en ? w_data : 8'd0;
    assign mac_bias    = 8'd0;
    assign y_data      = y_data_q;
    assign y_idx       = y_idx_q;
    assign y_valid     = (state_q == S_OUT);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mac_seq.sv
// Bench for mac_seq: three lanes with SHIFT = 0, 4, 2 share memories, start and
// y_ready, each with its own behavioural mac and sync-read memory ports.
module tb_mac_seq;
    localparam int N_IN  = 4;
    localparam int N_OUT = 2;
    localparam int XW    = 2;
    localparam int WW    = 3;
    localparam int NW    = 1;
    localparam int LANES = 3;
    localparam int E     = NW + 24;

    logic clk, rst, start, y_ready;
    logic          busy       [LANES];
    logic          done       [LANES];
    logic [XW-1:0] x_addr     [LANES];
    logic [7:0]    x_data     [LANES];
    logic [WW-1:0] w_addr     [LANES];
    logic [7:0]    w_data     [LANES];
    logic [NW-1:0] bias_addr  [LANES];
    logic [7:0]    bias_data  [LANES];
    logic          mac_rst    [LANES];
    logic          mac_en     [LANES];
    logic [7:0]    mac_a      [LANES];
    logic [7:0]    mac_b      [LANES];
    logic [7:0]    mac_bias   [LANES];
    logic [15:0]   mac_result [LANES];
    logic [7:0]    y_data     [LANES];
    logic [NW-1:0] y_idx      [LANES];
    logic          y_valid    [LANES];
    logic [2:0]    dbg_state  [LANES];

    logic [7:0] xmem [N_IN];
    logic [7:0] wmem [N_IN*N_OUT];
    logic [7:0] bmem [N_OUT];

    logic [E-1:0] exp_q[$];
    logic [E-1:0] e;
    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int run_len = 0;
    logic prev_mac_rst = 1'b0;
    logic exp_done = 1'b0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- DUT lanes ----------------
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        localparam int SH = (g == 0) ? 0 : ((g == 1) ? 4 : 2);
        mac_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .SHIFT(SH), .XW(XW), .WW(WW), .NW(NW)) dut (
            .CLKEXT(clk), .RST(rst), .start(start),
            .busy(busy[g]), .done(done[g]),
            .x_addr(x_addr[g]), .x_data(x_data[g]),
            .w_addr(w_addr[g]), .w_data(w_data[g]),
            .bias_addr(bias_addr[g]), .bias_data(bias_data[g]),
            .mac_rst(mac_rst[g]), .mac_en(mac_en[g]),
            .mac_a(mac_a[g]), .mac_b(mac_b[g]), .mac_bias(mac_bias[g]),
            .mac_result(mac_result[g]),
            .y_data(y_data[g]), .y_idx(y_idx[g]),
            .y_valid(y_valid[g]), .y_ready(y_ready),
            .dbg_state_o(dbg_state[g])
        );
        always @(posedge clk) begin
            x_data[g]    <= xmem[x_addr[g]];
            w_data[g]    <= wmem[w_addr[g]];
            bias_data[g] <= bmem[bias_addr[g]];
            if (rst || mac_rst[g]) mac_result[g] <= 16'd0;
            else if (mac_en[g])    mac_result[g] <= mac_result[g] + ({8'd0, mac_a[g]} * {8'd0, mac_b[g]});
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int shift_of(input int l);
        return (l == 0) ? 0 : ((l == 1) ? 4 : 2);
    endfunction

    // Reference: 16-bit wrapped dot product, plus bias, shift, clamp to 255.
    function automatic logic [7:0] model_y(input int sh, input int n);
        int unsigned acc = 0;
        int unsigned s;
        for (int i = 0; i < N_IN; i++) acc = acc + int'(xmem[i]) * int'(wmem[n*N_IN + i]);
        s = (acc % 65536) + int'(bmem[n]);
        s = s >> sh;
        return (s > 255) ? 8'd255 : s[7:0];
    endfunction

    task automatic push_exp();
        logic [E-1:0] ent;
        for (int n = 0; n < N_OUT; n++) begin
            ent = '0;
            ent[24 +: NW] = NW'(n);
            for (int l = 0; l < LANES; l++) ent[8*l +: 8] = model_y(shift_of(l), n);
            exp_q.push_back(ent);
        end
    endtask

    // Scoreboard and protocol monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            run_len      = 0;
            prev_mac_rst = 1'b0;
            exp_done     = 1'b0;
        end else begin
            if (mac_en[0]) begin
                if (run_len == 0) chk("mac_rst_before_en", prev_mac_rst, 1);
                run_len++;
            end else if (run_len != 0) begin
                chk("mac_en_run_len", run_len, N_IN);
                run_len = 0;
            end
            prev_mac_rst = mac_rst[0];
            if (y_valid[0]) chk("no_mac_en_in_out", mac_en[0], 0);
            if (done[0] || exp_done) chk("done_pulse", done[0], exp_done);
            if (done[0]) done_cnt++;
            exp_done = 1'b0;
            if (y_valid[0] && y_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("y_idx", y_idx[0], e[24 +: NW]);
                    for (int l = 0; l < LANES; l++) chk($sformatf("y_data_lane%0d", l), y_data[l], e[8*l +: 8]);
                    if (e[24 +: NW] == NW'(N_OUT - 1)) exp_done = 1'b1;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_all_zero(input string when);
        chk({when, "_busy"}, busy[0], 0);
        chk({when, "_done"}, done[0], 0);
        chk({when, "_y_valid"}, y_valid[0], 0);
        chk({when, "_mac_en"}, mac_en[0], 0);
        chk({when, "_mac_rst"}, mac_rst[0], 0);
        chk({when, "_mac_a"}, mac_a[0], 0);
        chk({when, "_mac_b"}, mac_b[0], 0);
        chk({when, "_mac_bias"}, mac_bias[0], 0);
        chk({when, "_x_addr"}, x_addr[0], 0);
        chk({when, "_w_addr"}, w_addr[0], 0);
        chk({when, "_bias_addr"}, bias_addr[0], 0);
        chk({when, "_y_data"}, y_data[0], 0);
        chk({when, "_y_idx"}, y_idx[0], 0);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done();
        int base = done_cnt;
        int n = 0;
        while (done_cnt == base && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("layer_done_seen", (done_cnt != base), 1);
    endtask

    task automatic run_layer();
        push_exp();
        pulse_start();
        wait_done();
    endtask

    task automatic load_a();
        for (int i = 0; i < N_IN; i++) begin
            xmem[i]        = 8'(i + 1);
            wmem[i]        = 8'd1;
            wmem[N_IN + i] = 8'd100;
        end
        bmem[0] = 8'd0;
        bmem[1] = 8'd24;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;
        int n;
        logic [7:0]    hold_d;
        logic [NW-1:0] hold_i;
        rst = 1'b1; start = 1'b0; y_ready = 1'b1;
        for (int i = 0; i < N_IN*N_OUT; i++) wmem[i] = 8'd0;
        for (int i = 0; i < N_IN; i++) xmem[i] = 8'd0;
        for (int i = 0; i < N_OUT; i++) bmem[i] = 8'd0;
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        @(posedge clk); #1 rst = 1'b0;

        // x=[1,2,3,4]: neuron0 dot 10, neuron1 dot 1000 + bias 24
        load_a();
        run_layer();

        // all 255: sum wraps to 63492, saturates in every lane
        for (int i = 0; i < N_IN; i++) xmem[i] = 8'd255;
        for (int i = 0; i < N_IN*N_OUT; i++) wmem[i] = 8'd255;
        for (int i = 0; i < N_OUT; i++) bmem[i] = 8'd0;
        run_layer();

        repeat (3) begin
            for (int i = 0; i < N_IN; i++) xmem[i] = 8'($urandom_range(0, 255));
            for (int i = 0; i < N_IN*N_OUT; i++) wmem[i] = 8'($urandom_range(0, 255));
            for (int i = 0; i < N_OUT; i++) bmem[i] = 8'($urandom_range(0, 255));
            run_layer();
        end

        // back-pressure in OUT for neuron 0
        load_a();
        y_ready = 1'b0;
        push_exp();
        pulse_start();
        n = 0;
        while (!y_valid[0] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("stall_reached_out", y_valid[0], 1);
        hold_d = y_data[0];
        hold_i = y_idx[0];
        repeat (5) begin
            @(posedge clk); #1;
            chk("stall_y_valid", y_valid[0], 1);
            chk("stall_y_data", y_data[0], hold_d);
            chk("stall_y_idx", y_idx[0], hold_i);
            chk("stall_mac_en", mac_en[0], 0);
        end
        y_ready = 1'b1;
        @(posedge clk); #1;
        chk("accept_then_clr", mac_rst[0], 1);
        chk("n1_w_addr_start", w_addr[0], N_IN);
        chk("n1_bias_addr", bias_addr[0], 1);
        wait_done();

        // reset while in RUN
        push_exp();
        pulse_start();
        @(posedge clk);
        @(posedge clk);
        #2 chk("in_run_before_rst", mac_en[0], 1);
        rst = 1'b1;
        #1 check_all_zero("mid_run_rst");
        exp_q.delete();
        base = done_cnt;
        @(posedge clk); #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        chk("no_done_after_abort", done_cnt, base);
        run_layer();

        // start while busy is ignored, one done per layer
        push_exp();
        pulse_start();
        base = done_cnt;
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done();
        repeat (10) @(posedge clk);
        #1;
        chk("no_queued_start", busy[0], 0);
        chk("single_done", done_cnt, base + 1);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
